// File: rtl/video_lvds_rx.sv
// 7:1 LVDS video deserializer.
// Shifts the three data lanes and the clock lane in at the bit clock. It locks onto the
// clock-lane frame word, rebuilds each 21-bit frame and decodes sync, data enable and
// 6-bit RGB from it.
//
// Ports:
//   clk, rst                      bit clock (7x dot clock), synchronous active-high reset
//   channel1..3, lvdsclk          sampled serial data lanes and LVDS clock lane
//   VideoData                     raw frame {lane3, lane2, lane1}
//   Red, Green, Blue              decoded 6-bit colour
//   HSync, VSync, DataEnable      decoded control bits
//   data_valid                    one-cycle strobe when a new frame is captured
//   locked                        high while aligned to the clock lane
module video_lvds_rx #(
  parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
  parameter int unsigned LOCK_COUNT  = 2,
  parameter int unsigned MISS_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        channel1,
  input  logic        channel2,
  input  logic        channel3,
  input  logic        lvdsclk,
  output logic [20:0] VideoData,
  output logic [5:0]  Red,
  output logic [5:0]  Green,
  output logic [5:0]  Blue,
  output logic        HSync,
  output logic        VSync,
  output logic        DataEnable,
  output logic        data_valid,
  output logic        locked
);

  localparam logic [3:0] LockCnt  = 4'(LOCK_COUNT);
  localparam logic [3:0] MissLmt  = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e     state_q, state_d;
  logic [6:0] sr_ch1_q, sr_ch2_q, sr_ch3_q, sr_clk_q;
  logic [2:0] phase_q, phase_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       capture;
  logic       boundary;
  logic       pat_match;

  // Decoded fields straight from the shift registers; sr[6] is the first bit received.
  logic [5:0] red_w, green_w, blue_w;

  assign red_w   = {sr_ch1_q[1], sr_ch1_q[2], sr_ch1_q[3], sr_ch1_q[4], sr_ch1_q[5],
                    sr_ch1_q[6]};
  assign green_w = {sr_ch2_q[2], sr_ch2_q[3], sr_ch2_q[4], sr_ch2_q[5], sr_ch2_q[6],
                    sr_ch1_q[0]};
  assign blue_w  = {sr_ch3_q[3], sr_ch3_q[4], sr_ch3_q[5], sr_ch3_q[6], sr_ch2_q[0],
                    sr_ch2_q[1]};

  assign boundary  = (phase_q == 3'd6);
  assign pat_match = (sr_clk_q == CLK_PATTERN);
  assign locked    = (state_q == StLocked);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    capture     = 1'b0;
    phase_d     = boundary ? 3'd0 : phase_q + 3'd1;

    case (state_q)
      StSearch: begin
        // Any cycle may hold the pattern; a hit defines the frame phase.
        if (pat_match) begin
          phase_d     = 3'd0;
          match_cnt_d = 4'd1;
          if (LockCnt <= 4'd1) begin
            state_d = StLocked;
            capture = 1'b1;
          end else begin
            state_d = StVerify;
          end
        end
      end
      StVerify: begin
        if (boundary) begin
          if (pat_match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_d >= LockCnt) begin
              state_d = StLocked;
              capture = 1'b1;
            end
          end else begin
            state_d     = StSearch;
            match_cnt_d = 4'd0;
          end
        end
      end
      StLocked: begin
        if (boundary) begin
          if (pat_match) begin
            capture    = 1'b1;
            miss_cnt_d = 4'd0;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d >= MissLmt) begin
              state_d     = StSearch;
              miss_cnt_d  = 4'd0;
              match_cnt_d = 4'd0;
            end
          end
        end
      end
      default: begin
        state_d = StSearch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSearch;
      sr_ch1_q    <= '0;
      sr_ch2_q    <= '0;
      sr_ch3_q    <= '0;
      sr_clk_q    <= '0;
      phase_q     <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      VideoData   <= '0;
      Red         <= '0;
      Green       <= '0;
      Blue        <= '0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      DataEnable  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_ch1_q    <= {sr_ch1_q[5:0], channel1};
      sr_ch2_q    <= {sr_ch2_q[5:0], channel2};
      sr_ch3_q    <= {sr_ch3_q[5:0], channel3};
      sr_clk_q    <= {sr_clk_q[5:0], lvdsclk};
      phase_q     <= phase_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      data_valid  <= capture;
      // Outputs hold between captures and through loss of lock.
      if (capture) begin
        VideoData  <= {sr_ch3_q, sr_ch2_q, sr_ch1_q};
        Red        <= red_w;
        Green      <= green_w;
        Blue       <= blue_w;
        HSync      <= sr_ch3_q[2];
        VSync      <= sr_ch3_q[1];
        DataEnable <= sr_ch3_q[0];
      end
    end
  end

endmodule

// File: tb/tb_video_lvds_rx.sv
// Self-checking bench for video_lvds_rx: lock/decode at every phase offset, false pattern
// rejection, miss tolerance and loss of lock, mid-frame reset and sync sequencing.
module tb_video_lvds_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        channel1 = 1'b0, channel2 = 1'b0, channel3 = 1'b0, lvdsclk = 1'b0;
  logic [20:0] VideoData;
  logic [5:0]  Red, Green, Blue;
  logic        HSync, VSync, DataEnable, data_valid, locked;

  video_lvds_rx dut (
    .clk        (clk),
    .rst        (rst),
    .channel1   (channel1),
    .channel2   (channel2),
    .channel3   (channel3),
    .lvdsclk    (lvdsclk),
    .VideoData  (VideoData),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue),
    .HSync      (HSync),
    .VSync      (VSync),
    .DataEnable (DataEnable),
    .data_valid (data_valid),
    .locked     (locked)
  );

  initial forever #5 clk = ~clk;

  localparam logic [6:0]  ClkOk  = 7'b1100011;
  localparam logic [6:0]  ClkBad = 7'b0000000;
  // Hand-built lanes: Red=101010 Green=000001 Blue=110011 HS=1 VS=0 DE=1.
  localparam logic [20:0] VdA    = {7'b0011101, 7'b0000011, 7'b0101011};
  localparam logic [20:0] VdBad  = 21'h1FFFFF;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int dv_cnt = 0;
  int first_dv_edge = -1;
  int last_drive_edge = 0;
  logic [2:0] cap_q[$];

  // Observes outputs 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    edge_cnt++;
    #1;
    if (data_valid === 1'b1) begin
      dv_cnt++;
      if (first_dv_edge < 0) first_dv_edge = edge_cnt;
      cap_q.push_back({HSync, VSync, DataEnable});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] encode(input logic [5:0] r, input logic [5:0] g,
                                         input logic [5:0] b, input logic hs,
                                         input logic vs, input logic de);
    logic [6:0] l1, l2, l3;
    l1 = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
    l2 = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
    l3 = {b[2], b[3], b[4], b[5], hs, vs, de};
    return {l3, l2, l1};
  endfunction

  // Drives frame bits hi downto lo (bit 6 first), one per cycle on the falling edge.
  task automatic send_frame(input logic [20:0] vd, input logic [6:0] ck, input int hi,
                            input int lo);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      channel1 = vd[i];
      channel2 = vd[7 + i];
      channel3 = vd[14 + i];
      lvdsclk  = ck[i];
      last_drive_edge = edge_cnt;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    channel1 = 1'b0;
    channel2 = 1'b0;
    channel3 = 1'b0;
    lvdsclk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_mon();
    dv_cnt = 0;
    first_dv_edge = -1;
    cap_q.delete();
  endtask

  logic [20:0] vd_b;
  logic [20:0] vd_t;
  logic [2:0]  tx_sync [8];
  int          exp_edge;

  initial begin
    tx_sync = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    vd_b = encode(6'h15, 6'h2C, 6'h0F, 1'b0, 1'b1, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_videodata", 32'(VideoData), 32'd0);
    check("rst_red", 32'(Red), 32'd0);

    // Lock and decode at every phase offset
    for (int off = 0; off < 7; off++) begin
      do_reset();
      clear_mon();
      for (int j = 0; j < off; j++) send_frame(21'h0, ClkBad, 0, 0);
      send_frame(VdA, ClkOk, 6, 0);
      send_frame(VdA, ClkOk, 6, 0);
      exp_edge = last_drive_edge + 2;
      send_frame(VdA, ClkOk, 6, 0);
      send_frame(VdA, ClkOk, 6, 0);
      send_frame(VdA, ClkOk, 6, 5);
      check($sformatf("first_dv_off%0d", off), 32'(first_dv_edge), 32'(exp_edge));
      check($sformatf("dv_count_off%0d", off), 32'(dv_cnt), 32'd3);
      check($sformatf("locked_off%0d", off), 32'(locked), 32'd1);
      check($sformatf("red_off%0d", off), 32'(Red), 32'h2A);
      check($sformatf("green_off%0d", off), 32'(Green), 32'h01);
      check($sformatf("blue_off%0d", off), 32'(Blue), 32'h33);
      check($sformatf("hsync_off%0d", off), 32'(HSync), 32'd1);
      check($sformatf("vsync_off%0d", off), 32'(VSync), 32'd0);
      check($sformatf("de_off%0d", off), 32'(DataEnable), 32'd1);
      check($sformatf("videodata_off%0d", off), 32'(VideoData),
            32'({7'b0011101, 7'b0000011, 7'b0101011}));
    end

    // False pattern: single clock word followed by a non-pattern word
    do_reset();
    clear_mon();
    send_frame(21'h0, ClkOk, 6, 0);
    send_frame(21'h0, ClkBad, 6, 0);
    send_frame(21'h0, ClkBad, 6, 0);
    send_frame(21'h0, ClkBad, 6, 0);
    check("false_locked", 32'(locked), 32'd0);
    check("false_dv", 32'(dv_cnt), 32'd0);
    send_frame(VdA, ClkOk, 6, 0);
    send_frame(VdA, ClkOk, 6, 0);
    send_frame(VdA, ClkOk, 6, 5);
    check("false_relock", 32'(locked), 32'd1);
    check("false_relock_dv", 32'(dv_cnt), 32'd1);

    // Miss tolerance: two bad frames then recovery
    do_reset();
    clear_mon();
    repeat (3) send_frame(VdA, ClkOk, 6, 0);
    send_frame(VdBad, ClkBad, 6, 0);
    send_frame(VdBad, ClkBad, 6, 0);
    send_frame(vd_b, ClkOk, 6, 5);
    check("miss2_locked", 32'(locked), 32'd1);
    check("miss2_dv", 32'(dv_cnt), 32'd2);
    check("miss2_red_hold", 32'(Red), 32'h2A);
    send_frame(vd_b, ClkOk, 4, 0);
    send_frame(vd_b, ClkOk, 6, 5);
    check("resume_dv", 32'(dv_cnt), 32'd3);
    check("resume_red", 32'(Red), 32'h15);
    check("resume_green", 32'(Green), 32'h2C);
    check("resume_blue", 32'(Blue), 32'h0F);
    check("resume_vsync", 32'(VSync), 32'd1);
    send_frame(vd_b, ClkOk, 4, 0);
    // Three bad frames: lock drops on the third bad boundary
    send_frame(VdBad, ClkBad, 6, 0);
    send_frame(VdBad, ClkBad, 6, 0);
    send_frame(VdBad, ClkBad, 6, 5);
    check("miss_2nd_locked", 32'(locked), 32'd1);
    send_frame(VdBad, ClkBad, 4, 0);
    send_frame(VdBad, ClkBad, 6, 5);
    check("miss3_locked", 32'(locked), 32'd0);
    check("miss3_dv", 32'(dv_cnt), 32'd4);
    check("miss3_red_hold", 32'(Red), 32'h15);
    check("miss3_vd_hold", 32'(VideoData), 32'(vd_b));

    // Reset mid-frame while locked
    do_reset();
    clear_mon();
    repeat (3) send_frame(VdA, ClkOk, 6, 0);
    send_frame(VdA, ClkOk, 6, 3);
    check("pre_rst_locked", 32'(locked), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_dv", 32'(data_valid), 32'd0);
    check("midrst_videodata", 32'(VideoData), 32'd0);
    check("midrst_rgb", 32'({Red, Green, Blue}), 32'd0);
    check("midrst_sync", 32'({HSync, VSync, DataEnable}), 32'd0);
    clear_mon();
    send_frame(VdA, ClkOk, 6, 0);
    send_frame(VdA, ClkOk, 6, 0);
    send_frame(VdA, ClkOk, 6, 5);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_dv", 32'(dv_cnt), 32'd1);
    check("relock_red", 32'(Red), 32'h2A);

    // Sync toggling across consecutive frames
    do_reset();
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      vd_t = encode(6'(i), 6'h00, 6'h00, tx_sync[i][2], tx_sync[i][1], tx_sync[i][0]);
      send_frame(vd_t, ClkOk, 6, 0);
    end
    send_frame(21'h0, ClkOk, 6, 5);
    check("sync_count", 32'(cap_q.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < cap_q.size()) check($sformatf("sync_frame%0d", k + 1), 32'(cap_q[k]),
                                  32'(tx_sync[k + 1]));
    end
    check("sync_last_red", 32'(Red), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
